// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the buffered UART transmitter: register map,
// STATUS bit layout and serializer states.
package uart_tx_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_COUNT   = 4;
  localparam int unsigned STAT_COUNT_W = 5;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally the cycle
// after it is pushed. Push while full is accepted only alongside a pop.
module uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  // Flush discards a same-cycle push outright.
  assign w_push = i_push & ~i_flush & (~o_full | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter on the UART core register port: TX FIFO,
// programmable baud divisor, status/control registers.
module uart_tx_buffered
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RST    = 434
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] write_data,
  input  logic        write_en,
  input  logic        i_uart_sel,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        irq_tx_empty_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             w_wr, w_wr_tx, w_wr_stat, w_wr_baud, w_wr_ctrl, w_flush;
  logic             w_full, w_empty, w_pop, w_can_start, w_baud_done;
  logic [7:0]       w_head;
  logic [CW-1:0]    w_count;
  logic [DIV_W-1:0] w_div_wr;
  logic             w_unused;

  logic             r_ovf, r_tx_en, r_tx, r_irq;
  logic [DIV_W-1:0] r_div, r_div_lat, r_baud;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  tx_state_t        r_state;

  tx_state_t        w_state_nxt;
  logic [DIV_W-1:0] w_div_lat_nxt, w_baud_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_bit_nxt;
  logic             w_tx_nxt;

  assign w_unused  = ^write_data;
  assign w_wr      = i_uart_sel & write_en;
  assign w_wr_tx   = w_wr & (addr_i == ADDR_TXDATA);
  assign w_wr_stat = w_wr & (addr_i == ADDR_STATUS);
  assign w_wr_baud = w_wr & (addr_i == ADDR_BAUD);
  assign w_wr_ctrl = w_wr & (addr_i == ADDR_CTRL);
  assign w_flush   = w_wr_ctrl & write_data[1];
  assign w_div_wr  = (write_data[DIV_W-1:0] < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN)
                                                               : write_data[DIV_W-1:0];

  uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_push  (w_wr_tx),
    .i_data  (write_data[7:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf   <= 1'b0;
      r_div   <= DIV_W'(DIV_RST);
      r_tx_en <= 1'b1;
    end else begin
      if (w_wr_tx && w_full && !w_pop && !w_flush) r_ovf <= 1'b1;
      else if (w_wr_stat && write_data[STAT_OVF])  r_ovf <= 1'b0;
      if (w_wr_baud) r_div   <= w_div_wr;
      if (w_wr_ctrl) r_tx_en <= write_data[0];
    end
  end

  assign w_can_start = r_tx_en & ~w_empty;
  assign w_baud_done = (r_baud == '0);

  // Frame start (from IDLE or end of STOP) pops the head and latches the divisor.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit;
    w_baud_nxt    = r_baud;
    w_div_lat_nxt = r_div_lat;
    w_pop         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_div_lat_nxt = r_div;
          w_baud_nxt    = r_div - DIV_W'(1);
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = r_div_lat - DIV_W'(1);
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = r_div_lat - DIV_W'(1);
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          if (w_can_start) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_div_lat_nxt = r_div;
            w_baud_nxt    = r_div - DIV_W'(1);
            w_state_nxt   = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - DIV_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    unique case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_baud    <= '0;
      r_div_lat <= DIV_W'(DIV_RST);
      r_tx      <= 1'b1;
      r_irq     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit     <= w_bit_nxt;
      r_baud    <= w_baud_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_tx      <= w_tx_nxt;
      r_irq     <= w_empty & (r_state == ST_IDLE);
    end
  end

  assign uart_tx        = r_tx;
  assign irq_tx_empty_o = r_irq;

  always_comb begin
    read_data = '0;
    unique case (addr_i)
      ADDR_STATUS: begin
        read_data[STAT_EMPTY] = w_empty;
        read_data[STAT_FULL]  = w_full;
        read_data[STAT_BUSY]  = (r_state != ST_IDLE);
        read_data[STAT_OVF]   = r_ovf;
        read_data[STAT_COUNT +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
      end
      ADDR_BAUD: read_data[DIV_W-1:0] = r_div;
      ADDR_CTRL: read_data[0]         = r_tx_en;
      default:   read_data            = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed register/timing checks plus a serial
// monitor that decodes frames and compares them against a byte scoreboard.
module tb_uart_tx_buffered;
  import uart_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int   errors = 0;
  int   checks = 0;
  int   tb_div = 434;
  bit   mon_en = 1'b1;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .FIFO_DEPTH (16),
    .DIV_W      (16),
    .DIV_RST    (434)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .addr_i         (addr),
    .write_data     (wdata),
    .write_en       (wen),
    .i_uart_sel     (sel),
    .read_data      (rdata),
    .uart_tx        (tx),
    .irq_tx_empty_o (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; sel = 1'b1; wen = 1'b1;
    @(negedge clk);
    sel = 1'b0; wen = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, irq, 1);
  endtask

  // Serial monitor: samples mid-bit using the divisor the bench programmed.
  initial begin : monitor
    int d;
    int off;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        d   = tb_div;
        off = 0;
        b   = '0;
        for (int k = 0; k < 10; k++) begin
          repeat (k * d + d / 2 - off) @(negedge clk);
          off = k * d + d / 2;
          if (k == 0)      check("mon_start_bit", tx, 0);
          else if (k == 9) check("mon_stop_bit", tx, 1);
          else             b[k-1] = tx;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_frame: got 0x%02h expected no frame", b);
        end else begin
          check("mon_byte", b, exp_q.pop_front());
        end
        repeat (10 * d - 1 - off) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] pat;
    logic       e;
    int         n, low, high;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    rst_n = 1'b1;
    read_check(ADDR_STATUS, 32'h1, "rst_status");
    check("rst_irq", irq, 1);
    check("rst_tx_idle", tx, 1);
    read_check(ADDR_BAUD, 32'd434, "rst_baud");
    read_check(ADDR_CTRL, 32'h1, "rst_ctrl");
    read_check(ADDR_TXDATA, 32'h0, "txdata_reads_zero");

    // Exact frame timing for 0x55 at divisor 4
    bus_write(ADDR_BAUD, 32'd4);
    tb_div = 4;
    read_check(ADDR_BAUD, 32'd4, "baud4");
    pat = 8'h55;
    exp_q.push_back(pat);
    bus_write(ADDR_TXDATA, 32'h55);
    addr = ADDR_STATUS;
    for (int c = 1; c <= 43; c++) begin
      #1;
      if (c == 1)       e = 1'b1;
      else if (c <= 5)  e = 1'b0;
      else if (c <= 37) e = pat[(c - 6) / 4];
      else              e = 1'b1;
      check($sformatf("tx_timing_c%0d", c), tx, e);
      if (c == 41) check("busy_before_end", rdata[STAT_BUSY], 1);
      if (c == 42) begin
        check("busy_falls", rdata[STAT_BUSY], 0);
        check("irq_still_low", irq, 0);
      end
      if (c == 43) check("irq_rises", irq, 1);
      @(negedge clk);
    end

    // Divisor clamp and 20-cycle frame at divisor 2
    bus_write(ADDR_BAUD, 32'd0);
    read_check(ADDR_BAUD, 32'd2, "baud_clamp0");
    bus_write(ADDR_BAUD, 32'd1);
    read_check(ADDR_BAUD, 32'd2, "baud_clamp1");
    tb_div = 2;
    exp_q.push_back(8'h00);
    bus_write(ADDR_TXDATA, 32'h00);
    addr = ADDR_STATUS;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("len_start_seen", tx, 0);
    low = 0;
    while (tx === 1'b0 && low < 40) begin low++; @(negedge clk); end
    check("len_low_cycles", low, 18);
    high = 0;
    while (rdata[STAT_BUSY] === 1'b1 && high < 40) begin high++; @(negedge clk); end
    check("len_stop_cycles", high, 2);

    // Overflow with transmitter disabled, then drain
    bus_write(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      bus_write(ADDR_TXDATA, 32'(i));
    end
    read_check(ADDR_STATUS, 32'h10A, "status_full_ovf");
    bus_write(ADDR_STATUS, 32'h8);
    read_check(ADDR_STATUS, 32'h102, "status_ovf_cleared");
    read_check(ADDR_CTRL, 32'h0, "ctrl_disabled");
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle(16 * 20 + 50, "drain_idle");
    read_check(ADDR_STATUS, 32'h1, "status_drained");

    // Back-to-back frames at divisor 4
    bus_write(ADDR_BAUD, 32'd4);
    tb_div = 4;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(negedge clk);
    addr = ADDR_TXDATA; wdata = 32'h3C; sel = 1'b1; wen = 1'b1;
    @(negedge clk);
    wdata = 32'hC3;
    @(negedge clk);
    sel = 1'b0; wen = 1'b0;
    addr = ADDR_STATUS;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("b2b_start_seen", tx, 0);
    for (int t = 0; t <= 80; t++) begin
      if (t == 39) check("b2b_stop1_high", tx, 1);
      if (t == 40) check("b2b_start2_low", tx, 0);
      if (t == 79) check("b2b_busy_79", rdata[STAT_BUSY], 1);
      if (t == 80) check("b2b_idle_80", rdata[STAT_BUSY], 0);
      @(negedge clk);
    end

    // Flush during frame 1 data bits
    exp_q.push_back(8'hA1);
    @(negedge clk);
    addr = ADDR_TXDATA; wdata = 32'hA1; sel = 1'b1; wen = 1'b1;
    @(negedge clk);
    wdata = 32'hB2;
    @(negedge clk);
    wdata = 32'hC3;
    @(negedge clk);
    sel = 1'b0; wen = 1'b0;
    repeat (8) @(negedge clk);
    bus_write(ADDR_CTRL, 32'h3);
    wait_idle(200, "flush_idle");
    read_check(ADDR_STATUS, 32'h1, "status_after_flush");
    read_check(ADDR_CTRL, 32'h1, "ctrl_flush_selfclear");

    // Asynchronous reset mid-frame
    mon_en = 1'b0;
    bus_write(ADDR_TXDATA, 32'h00);
    repeat (6) @(negedge clk);
    check("pre_reset_low", tx, 0);
    addr = ADDR_STATUS;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_irq", irq, 1);
    check("async_reset_status", rdata, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    read_check(ADDR_BAUD, 32'd434, "post_reset_baud");

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
